// File: rtl/eip_sequencer.sv
// Next-EIP controller: arbitrates sequential advance, jumps, call/ret and
// interrupt entry into one registered EIP, backed by a small return-address stack.
module eip_sequencer #(
  parameter logic [31:0] RESET_EIP = 32'h0000_0000,
  parameter int          RAS_DEPTH = 8,
  parameter int          RAS_AW    = 3
) (
  input  logic              clock_8,
  input  logic              reset,
  input  logic              instr_valid,
  input  logic [3:0]        instr_len,
  input  logic [2:0]        br_type,
  input  logic [31:0]       br_target,
  input  logic              stall,
  input  logic              irq_req,
  input  logic [31:0]       irq_vector,
  output logic              irq_ack,
  output logic [31:0]       eip,
  output logic              eip_update,
  output logic [RAS_AW:0]   ras_count,
  output logic              fault,
  output logic [1:0]        fault_code
);

  typedef enum logic [1:0] {S_RUN, S_IRQ, S_HALT} state_t;

  localparam logic [RAS_AW:0] RAS_FULL = (RAS_AW+1)'(RAS_DEPTH);

  state_t              r_state;
  logic [31:0]         r_eip;
  logic [RAS_AW:0]     r_count;
  logic                r_eip_update;
  logic                r_irq_ack;
  logic                r_fault;
  logic [1:0]          r_code;
  logic [31:0]         r_ras [RAS_DEPTH];

  state_t              w_state_nxt;
  logic [31:0]         w_eip_nxt;
  logic [31:0]         w_seq;
  logic [31:0]         w_push_data;
  logic [RAS_AW-1:0]   w_push_idx;
  logic [RAS_AW-1:0]   w_top_idx;
  logic                w_eip_we;
  logic                w_push;
  logic                w_pop;
  logic                w_ack;
  logic                w_fault;
  logic [1:0]          w_code;
  logic                w_full;
  logic                w_empty;

  assign w_seq      = r_eip + {28'd0, instr_len};
  assign w_full     = (r_count == RAS_FULL);
  assign w_empty    = (r_count == '0);
  assign w_push_idx = r_count[RAS_AW-1:0];
  assign w_top_idx  = r_count[RAS_AW-1:0] - 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_eip_nxt   = r_eip;
    w_eip_we    = 1'b0;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_push_data = r_eip;
    w_ack       = 1'b0;
    w_fault     = 1'b0;
    w_code      = 2'd0;
    case (r_state)
      S_RUN: begin
        if (!stall) begin
          if (instr_valid) begin
            if (instr_len == 4'd0 || br_type > 3'd4) begin
              w_fault = 1'b1;
              w_code  = 2'd3;
            end else begin
              case (br_type)
                3'd0: begin w_eip_nxt = w_seq;             w_eip_we = 1'b1; end
                3'd1: begin w_eip_nxt = br_target;         w_eip_we = 1'b1; end
                3'd2: begin w_eip_nxt = w_seq + br_target; w_eip_we = 1'b1; end
                3'd3: begin
                  if (w_full) begin
                    w_fault = 1'b1;
                    w_code  = 2'd1;
                  end else begin
                    w_push      = 1'b1;
                    w_push_data = w_seq;
                    w_eip_nxt   = br_target;
                    w_eip_we    = 1'b1;
                  end
                end
                3'd4: begin
                  if (w_empty) begin
                    w_fault = 1'b1;
                    w_code  = 2'd2;
                  end else begin
                    w_pop     = 1'b1;
                    w_eip_nxt = r_ras[w_top_idx];
                    w_eip_we  = 1'b1;
                  end
                end
                default: ;
              endcase
            end
            // A retire that faults must not also enter the interrupt.
            if (!w_fault && irq_req) w_state_nxt = S_IRQ;
          end else if (irq_req) begin
            w_state_nxt = S_IRQ;
          end
        end
      end
      S_IRQ: begin
        w_state_nxt = S_RUN;
        if (w_full) begin
          w_fault = 1'b1;
          w_code  = 2'd1;
        end else begin
          w_push      = 1'b1;
          w_push_data = r_eip;
          w_eip_nxt   = irq_vector;
          w_eip_we    = 1'b1;
          w_ack       = 1'b1;
        end
      end
      default: ;
    endcase
    if (w_fault) w_state_nxt = S_HALT;
  end

  always_ff @(posedge clock_8) begin
    if (reset) begin
      r_state      <= S_RUN;
      r_eip        <= RESET_EIP;
      r_count      <= '0;
      r_eip_update <= 1'b0;
      r_irq_ack    <= 1'b0;
      r_fault      <= 1'b0;
      r_code       <= 2'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_eip_update <= w_eip_we;
      r_irq_ack    <= w_ack;
      if (w_eip_we) r_eip <= w_eip_nxt;
      if (w_push)     r_count <= r_count + 1'b1;
      else if (w_pop) r_count <= r_count - 1'b1;
      if (w_fault) begin
        r_fault <= 1'b1;
        r_code  <= w_code;
      end
    end
  end

  // Stack storage carries no reset; only ras_count qualifies its contents.
  always_ff @(posedge clock_8) begin
    if (!reset && w_push) r_ras[w_push_idx] <= w_push_data;
  end

  assign eip        = r_eip;
  assign eip_update = r_eip_update;
  assign irq_ack    = r_irq_ack;
  assign ras_count  = r_count;
  assign fault      = r_fault;
  assign fault_code = r_code;

endmodule
